// File: rtl/g32_window3x3.sv
// 3x3 window builder: delays the {top,mid,bot} column stream by one and two pixels per channel
// and emits {L,C,R} windows with horizontal zero padding. Option: G32_WIN_SIGN_EN adds o_sign.
module g32_window3x3 #(
   parameter int unsigned WIDTH_D = 27,
   parameter int unsigned SIZE    = 28,
   parameter int unsigned CHANNEL = 128
) (
   input  logic                   i_sclk,
   input  logic                   i_rst_n,
   input  logic                   i_vsync,
   input  logic                   i_reuse,
   input  logic                   i_valid,
   input  logic [3*WIDTH_D-1:0]   i_tdata,
   output logic                   o_valid,
   output logic                   o_sol,
   output logic                   o_eol,
   output logic                   o_reuse,
   output logic [9*WIDTH_D-1:0]   o_tdata,
   output logic                   o_err
`ifdef G32_WIN_SIGN_EN
   ,
   output logic [17:0]            o_sign
`endif
);

   localparam int unsigned CW = (CHANNEL > 1) ? $clog2(CHANNEL) : 1;
   localparam int unsigned PW = (SIZE > 1) ? $clog2(SIZE) : 1;
   localparam int unsigned DW = 3 * WIDTH_D;
   localparam logic [CW-1:0] ChLast = CW'(CHANNEL - 1);
   localparam logic [PW-1:0] PxLast = PW'(SIZE - 1);

   typedef enum logic [1:0] {StIdle, StFill, StRun, StFlush} state_e;

   state_e         state_q, state_d;
   logic [CW-1:0]  ch_q, ch_d;
   logic [PW-1:0]  px_q, px_d;
   logic [DW-1:0]  d1_mem [CHANNEL];
   logic [DW-1:0]  d2_mem [CHANNEL];
   logic [DW-1:0]  d1_rd, d2_rd;
   logic           clr, flush, acc, ch_last, px_last;

   logic           win_valid, win_sol, win_eol;
   logic [DW-1:0]  win_l, win_c, win_r;
   logic [3*DW-1:0] win_data;

   logic           valid_q, sol_q, eol_q, reuse_q, err_q, row_reuse_q;
   logic [3*DW-1:0] tdata_q;

   assign clr     = !i_rst_n || i_vsync;
   assign flush   = (state_q == StFlush);
   // Beats arriving during flush are dropped; they only raise o_err.
   assign acc     = i_valid && !clr && !flush;
   assign ch_last = (ch_q == ChLast);
   assign px_last = (px_q == PxLast);
   assign d1_rd   = d1_mem[ch_q];
   assign d2_rd   = d2_mem[ch_q];

   // Delay lines: contents survive reset and vsync.
   always_ff @(posedge i_sclk) begin
      if (acc) begin
         d1_mem[ch_q] <= i_tdata;
         d2_mem[ch_q] <= d1_rd;
      end
   end

   always_comb begin
      ch_d = ch_q;
      px_d = px_q;
      if (acc || flush) begin
         ch_d = ch_last ? '0 : ch_q + CW'(1);
      end
      if (acc && ch_last) begin
         px_d = px_last ? '0 : px_q + PW'(1);
      end
   end

   always_ff @(posedge i_sclk) begin
      if (clr) begin
         state_q <= StIdle;
         ch_q    <= '0;
         px_q    <= '0;
      end else begin
         state_q <= state_d;
         ch_q    <= ch_d;
         px_q    <= px_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle, StFill: begin
            if (acc) begin
               if (ch_last) begin
                  state_d = (SIZE == 1) ? StFlush : StRun;
               end else begin
                  state_d = StFill;
               end
            end
         end
         StRun: begin
            if (acc && ch_last && px_last) begin
               state_d = StFlush;
            end
         end
         StFlush: begin
            if (ch_last) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Window for the centre column x-1 (RUN) or SIZE-1 (FLUSH, f == ch_q).
   always_comb begin
      win_valid = 1'b0;
      win_sol   = 1'b0;
      win_eol   = 1'b0;
      win_l     = '0;
      win_c     = d1_rd;
      win_r     = '0;
      unique case (state_q)
         StRun: begin
            if (acc) begin
               win_valid = 1'b1;
               win_l     = (px_q == PW'(1)) ? '0 : d2_rd;
               win_r     = i_tdata;
               win_sol   = (px_q == PW'(1)) && (ch_q == '0);
            end
         end
         StFlush: begin
            win_valid = 1'b1;
            win_l     = (SIZE == 1) ? '0 : d2_rd;
            win_sol   = (SIZE == 1) && (ch_q == '0);
            win_eol   = ch_last;
         end
         default: ;
      endcase
   end

   assign win_data = {win_l, win_c, win_r};

   always_ff @(posedge i_sclk) begin
      if (clr) begin
         valid_q     <= 1'b0;
         sol_q       <= 1'b0;
         eol_q       <= 1'b0;
         reuse_q     <= 1'b0;
         tdata_q     <= '0;
         err_q       <= 1'b0;
         row_reuse_q <= 1'b0;
      end else begin
         valid_q <= win_valid;
         sol_q   <= win_sol;
         eol_q   <= win_eol;
         if (win_valid) begin
            tdata_q <= win_data;
            reuse_q <= row_reuse_q;
         end
         if (i_valid && flush) begin
            err_q <= 1'b1;
         end
         if (acc && (px_q == '0) && (ch_q == '0)) begin
            row_reuse_q <= i_reuse;
         end
      end
   end

   assign o_valid = valid_q;
   assign o_sol   = sol_q;
   assign o_eol   = eol_q;
   assign o_reuse = reuse_q;
   assign o_tdata = tdata_q;
   assign o_err   = err_q;

`ifdef G32_WIN_SIGN_EN
   logic [17:0] sign_d, sign_q;

   always_comb begin
      sign_d = '0;
      for (int i = 0; i < 9; i++) begin
         if (win_data[i*WIDTH_D +: WIDTH_D] == '0) begin
            sign_d[2*i +: 2] = 2'b00;
         end else if (win_data[i*WIDTH_D + WIDTH_D - 1]) begin
            sign_d[2*i +: 2] = 2'b11;
         end else begin
            sign_d[2*i +: 2] = 2'b01;
         end
      end
   end

   always_ff @(posedge i_sclk) begin
      if (clr) begin
         sign_q <= '0;
      end else if (win_valid) begin
         sign_q <= sign_d;
      end
   end

   assign o_sign = sign_q;
`endif

endmodule

// File: tb/tb_g32_window3x3.sv
// Scoreboard bench for g32_window3x3 (SIZE=4, CHANNEL=2): random column data, random gaps,
// reset/vsync aborts and flush-overlap error checks against a column-array window model.
module tb_g32_window3x3;

   localparam int unsigned W  = 27;
   localparam int unsigned S  = 4;
   localparam int unsigned CH = 2;
   localparam int unsigned DW = 3 * W;

   logic            clk = 1'b0;
   logic            i_rst_n, i_vsync, i_reuse, i_valid;
   logic [DW-1:0]   i_tdata;
   logic            o_valid, o_sol, o_eol, o_reuse, o_err;
   logic [3*DW-1:0] o_tdata;
`ifdef G32_WIN_SIGN_EN
   logic [17:0]     o_sign;
`endif

   always #5 clk = ~clk;

   g32_window3x3 #(.WIDTH_D(W), .SIZE(S), .CHANNEL(CH)) dut (
      .i_sclk  (clk),
      .i_rst_n (i_rst_n),
      .i_vsync (i_vsync),
      .i_reuse (i_reuse),
      .i_valid (i_valid),
      .i_tdata (i_tdata),
      .o_valid (o_valid),
      .o_sol   (o_sol),
      .o_eol   (o_eol),
      .o_reuse (o_reuse),
      .o_tdata (o_tdata),
      .o_err   (o_err)
`ifdef G32_WIN_SIGN_EN
      ,
      .o_sign  (o_sign)
`endif
   );

   typedef struct {
      logic [3*DW-1:0] data;
      bit              sol;
      bit              eol;
      bit              reuse;
      int unsigned     when;
   } exp_t;

   exp_t          exp_q[$];
   int unsigned   n_cmp = 0;
   int unsigned   n_bad = 0;
   int unsigned   neg_cnt = 0;
   logic [DW-1:0] col [S][CH];
   bit            row_reuse;

   // Monitor: pops one expected window per presented beat, checks content and cycle.
   always @(negedge clk) begin
      exp_t e;
      neg_cnt++;
      if (o_valid) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_beat: got o_valid=1 data=%h at %0d, required no output",
                     o_tdata, neg_cnt);
         end else begin
            e = exp_q.pop_front();
            if (o_tdata !== e.data || o_sol !== e.sol || o_eol !== e.eol ||
                o_reuse !== e.reuse || neg_cnt != e.when) begin
               n_bad++;
               $display("FAIL window_beat: got data=%h sol=%0b eol=%0b reuse=%0b at %0d, required data=%h sol=%0b eol=%0b reuse=%0b at %0d",
                        o_tdata, o_sol, o_eol, o_reuse, neg_cnt,
                        e.data, e.sol, e.eol, e.reuse, e.when);
            end
`ifdef G32_WIN_SIGN_EN
            begin
               logic [17:0] sg;
               logic [W-1:0] tp;
               for (int i = 0; i < 9; i++) begin
                  tp = e.data[i*W +: W];
                  sg[2*i +: 2] = (tp == 0) ? 2'b00 : (tp[W-1] ? 2'b11 : 2'b01);
               end
               n_cmp++;
               if (o_sign !== sg) begin
                  n_bad++;
                  $display("FAIL sign_code: got %h, required %h", o_sign, sg);
               end
            end
`endif
         end
      end else if (exp_q.size() > 0 && exp_q[0].when <= neg_cnt) begin
         e = exp_q.pop_front();
         n_cmp++;
         n_bad++;
         $display("FAIL missing_beat: got o_valid=0 at %0d, required data=%h at %0d",
                  neg_cnt, e.data, e.when);
      end
   end

   function automatic logic [DW-1:0] rnd();
      logic [95:0] t;
      t = {$urandom(), $urandom(), $urandom()};
      return t[DW-1:0];
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h", name, got, want);
      end
   endtask

   task automatic check_cleared(input string tag);
      check({tag, "_valid"}, 32'(o_valid), 32'd0);
      check({tag, "_sol"},   32'(o_sol),   32'd0);
      check({tag, "_eol"},   32'(o_eol),   32'd0);
      check({tag, "_reuse"}, 32'(o_reuse), 32'd0);
      check({tag, "_tdata_nonzero"}, 32'(|o_tdata), 32'd0);
      check({tag, "_err"},   32'(o_err),   32'd0);
   endtask

   task automatic drive(input bit v, input logic [DW-1:0] d, input bit rst_n, input bit vs,
                        input bit reuse);
      @(posedge clk);
      #1;
      i_valid = v;
      i_tdata = d;
      i_rst_n = rst_n;
      i_vsync = vs;
      i_reuse = reuse;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, rnd(), 1'b1, 1'b0, 1'($urandom_range(0, 1)));
   endtask

   // One accepted beat (x,c); expected windows follow from the column neighbourhood.
   task automatic beat(input int x, input int c, input int nflush);
      logic [DW-1:0] d;
      logic [DW-1:0] l;
      exp_t          e;
      int unsigned   base;
      d = rnd();
      drive(1'b1, d, 1'b1, 1'b0, (x == 0 && c == 0) ? row_reuse : 1'($urandom_range(0, 1)));
      base = neg_cnt;
      col[x][c] = d;
      if (x >= 1) begin
         l = '0;
         if (x >= 2) l = col[x-2][c];
         e.data  = {l, col[x-1][c], d};
         e.sol   = (x == 1 && c == 0);
         e.eol   = 1'b0;
         e.reuse = row_reuse;
         e.when  = base + 2;
         exp_q.push_back(e);
      end
      if (x == S - 1 && c == CH - 1) begin
         for (int f = 0; f < nflush; f++) begin
            e.data  = {col[S-2][f], col[S-1][f], {DW{1'b0}}};
            e.sol   = 1'b0;
            e.eol   = (f == CH - 1);
            e.reuse = row_reuse;
            e.when  = base + 3 + f;
            exp_q.push_back(e);
         end
      end
   endtask

   task automatic row(input int gap_max, input int nflush);
      row_reuse = 1'($urandom_range(0, 1));
      for (int x = 0; x < S; x++) begin
         for (int c = 0; c < CH; c++) begin
            if (gap_max > 0) idle($urandom_range(0, gap_max));
            beat(x, c, nflush);
         end
      end
   endtask

   initial begin
      i_rst_n = 1'b0;
      i_vsync = 1'b0;
      i_reuse = 1'b0;
      i_valid = 1'b0;
      i_tdata = '0;
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, rnd(), 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      check_cleared("reset");
      idle(2);

      // Continuous row, then gapped rows.
      row(0, CH);
      idle(CH + 2);
      repeat (4) begin
         row(2, CH);
         idle(CH + $urandom_range(0, 3));
      end

      // Reset in the middle of RUN at x=2.
      row_reuse = 1'b1;
      for (int x = 0; x < 2; x++) for (int c = 0; c < CH; c++) beat(x, c, CH);
      beat(2, 0, CH);
      drive(1'b1, rnd(), 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      @(negedge clk);
      check_cleared("midrun_reset");
      idle(2);
      row(0, CH);
      idle(CH + 1);

      // vsync mid-row abandons the row without a flush.
      row_reuse = 1'b0;
      for (int x = 0; x < 2; x++) for (int c = 0; c < CH; c++) beat(x, c, CH);
      drive(1'b1, rnd(), 1'b1, 1'b1, 1'b1);
      idle(3);
      row(1, CH);
      idle(CH + 1);

      // vsync on the second flush cycle: only the first flush beat appears.
      row(0, 1);
      idle(1);
      drive(1'b0, rnd(), 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      @(negedge clk);
      check("vsync_flush_valid", 32'(o_valid), 32'd0);
      check("vsync_flush_err", 32'(o_err), 32'd0);
      idle(CH + 2);
      row(0, CH);
      idle(CH + 1);

      // Beat during flush: dropped, sticky error, flush still complete.
      row(0, CH);
      idle(1);
      drive(1'b1, rnd(), 1'b1, 1'b0, 1'b1);
      idle(CH);
      check("err_set", 32'(o_err), 32'd1);
      row(1, CH);
      idle(CH + 1);
      check("err_sticky", 32'(o_err), 32'd1);
      drive(1'b0, rnd(), 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      @(negedge clk);
      check("err_vsync_clear", 32'(o_err), 32'd0);
      idle(2);
      row(2, CH);
      idle(CH + 6);

      check("leftover_expected", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
